// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: LINES x WORDS_PER_LINE words, sequential line fill with early word forward.
// Optional hit/miss counters are built only when ICACHE_PERF_EN is defined.
module icache_dm #(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   output logic              ready,
   output logic [31:0]       inst,
   output logic              ack,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_valid,
   input  logic              mem_busy
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   localparam int WB = $clog2(WORDS_PER_LINE);
   localparam int IB = $clog2(LINES);
   localparam int TB = ADDR_W - IB - WB - 2;
   localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, HIT_RESP, FILL_REQ, FILL_WAIT} state_t;

   state_t state, state_next;

   logic [WB-1:0] a_word;
   logic [IB-1:0] a_idx;
   logic [TB-1:0] a_tag;

   logic [LINES-1:0] valid;
   logic [TB-1:0]    tag_mem [LINES];
   logic [31:0]      data    [LINES][WORDS_PER_LINE];

   logic [TB-1:0] tag_q;
   logic [IB-1:0] idx_q;
   logic [WB-1:0] word_q;
   logic [WB-1:0] cnt_q;
   logic          ack_q;
   logic [31:0]   inst_q;

   logic hit, accept, fill_wr, fill_last;
   logic unused_addr_bits;

   assign a_word = addr[WB+1:2];
   assign a_idx  = addr[IB+WB+1:WB+2];
   assign a_tag  = addr[ADDR_W-1:IB+WB+2];
   assign unused_addr_bits = ^addr[1:0];

   assign hit       = valid[a_idx] && (tag_mem[a_idx] == a_tag);
   assign accept    = req && (state == IDLE);
   assign fill_wr   = mem_valid && (state == FILL_WAIT);
   assign fill_last = (cnt_q == LAST_WORD);

   assign ack  = ack_q;
   assign inst = inst_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
      state_next = state;
      ready      = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (req) state_next = hit ? HIT_RESP : FILL_REQ;
         end
         HIT_RESP: state_next = IDLE;
         FILL_REQ: begin
            mem_addr = {tag_q, idx_q, cnt_q, 2'b00};
            if (!mem_busy) begin
               mem_req    = 1'b1;
               state_next = FILL_WAIT;
            end
         end
         FILL_WAIT: begin
            mem_addr = {tag_q, idx_q, cnt_q, 2'b00};
            if (mem_valid) state_next = fill_last ? IDLE : FILL_REQ;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture, fill counter, line valid bits and the registered ack/inst pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= '0;
         tag_q  <= '0;
         idx_q  <= '0;
         word_q <= '0;
         cnt_q  <= '0;
         ack_q  <= 1'b0;
         inst_q <= '0;
      end else begin
         ack_q  <= 1'b0;
         inst_q <= '0;
         if (accept) begin
            tag_q  <= a_tag;
            idx_q  <= a_idx;
            word_q <= a_word;
            if (hit) begin
               ack_q  <= 1'b1;
               inst_q <= data[a_idx][a_word];
            end else begin
               valid[a_idx] <= 1'b0;
               cnt_q        <= '0;
            end
         end
         if (fill_wr) begin
            if (cnt_q == word_q) begin
               ack_q  <= 1'b1;
               inst_q <= mem_rdata;
            end
            if (fill_last) valid[idx_q] <= 1'b1;
            else           cnt_q        <= cnt_q + 1'b1;
         end
      end
   end

   // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether their contents are used.
   always_ff @(posedge clk) begin
      if (fill_wr) begin
         data[idx_q][cnt_q] <= mem_rdata;
         if (fill_last) tag_mem[idx_q] <= tag_q;
      end
   end

`ifdef ICACHE_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (accept) begin
         if (hit && hit_cnt != '1)        hit_cnt  <= hit_cnt + 32'd1;
         else if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm (default geometry): cold miss, hit, conflict, busy stall, reset mid-fill, dropped req.
// Build with ICACHE_PERF_EN defined to also check the hit/miss counters.
module tb_icache_dm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] inst;
   logic        ack;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata = 32'h0;
   logic        resp_valid = 1'b0;
   logic        stray_valid;
   logic        mem_valid;
   logic        mem_busy;
`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   assign mem_valid = resp_valid | stray_valid;

   icache_dm dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .addr      (addr),
      .ready     (ready),
      .inst      (inst),
      .ack       (ack),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
      .mem_busy  (mem_busy)
`ifdef ICACHE_PERF_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int ack_cnt = 0;
   int ack_cyc = 0;
   int bad_inst = 0;
   logic [31:0] ack_inst = 32'h0;
   logic [31:0] memlog [$];
   int          vcyc [$];
   bit          pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int req_cyc, ready_cyc;
   int lb, vb, ab;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 | {16'h0, a[15:0]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: answers each mem_req one cycle later; a reset cancels any pending reply.
   always @(negedge clk) begin
      resp_valid = 1'b0;
      mem_rdata  = 32'h0;
      if (!rst_n) pend = 1'b0;
      else begin
         if (pend) begin
            resp_valid = 1'b1;
            mem_rdata  = mem_word(pend_addr);
            pend       = 1'b0;
         end
         if (mem_req) begin
            memlog.push_back(mem_addr);
            pend      = 1'b1;
            pend_addr = mem_addr;
         end
      end
      if (resp_valid) vcyc.push_back(cyc);
   end

   always @(negedge clk) begin
      if (ack === 1'b1) begin
         ack_cnt++;
         ack_inst = inst;
         ack_cyc  = cyc;
      end else if (inst !== 32'h0) bad_inst++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic [31:0] a);
      @(posedge clk); #1;
      req  = 1'b1;
      addr = a;
      @(posedge clk); #1;
      req_cyc = cyc;
      req     = 1'b0;
   endtask

   task automatic wait_ready(input int budget, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ready !== 1'b1 && n < budget);
      ready_cyc = cyc;
      check(tag, {31'h0, ready}, 32'h1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mark();
      lb = memlog.size();
      vb = vcyc.size();
      ab = ack_cnt;
   endtask

   initial begin
      rst_n = 1'b0; req = 1'b0; addr = 32'h0; mem_busy = 1'b0; stray_valid = 1'b0;
      idle(3);
      check("rst_ready",    {31'h0, ready},   32'h1);
      check("rst_ack",      {31'h0, ack},     32'h0);
      check("rst_inst",     inst,             32'h0);
      check("rst_mem_req",  {31'h0, mem_req}, 32'h0);
      check("rst_mem_addr", mem_addr,         32'h0);
      rst_n = 1'b1;

      // Cold miss on 0x48: line 0x40..0x4C fetched in order, early ack after the third word.
      mark();
      do_req(32'h48);
      wait_ready(60, "cold_ready");
      idle(2);
      check("cold_nreq", memlog.size() - lb, 4);
      for (int i = 0; i < 4; i++) check("cold_addr", memlog[lb+i], 32'h40 + 32'(4*i));
      check("cold_acks", ack_cnt - ab, 1);
      check("cold_inst", ack_inst, 32'hC0DE_0048);
      check("cold_ack_lat", ack_cyc, vcyc[vb+2] + 1);
      check("cold_ready_lat", ready_cyc, vcyc[vb+3] + 1);

      // Hit on the freshly filled line.
      mark();
      do_req(32'h44);
      idle(3);
      check("hit_acks", ack_cnt - ab, 1);
      check("hit_inst", ack_inst, 32'hC0DE_0044);
      check("hit_nreq", memlog.size() - lb, 0);
      check("hit_lat", ack_cyc, req_cyc);
`ifdef ICACHE_PERF_EN
      check("perf_hit", hit_cnt, 32'd1);
      check("perf_miss", miss_cnt, 32'd1);
`endif

      // req held high for 4 cycles over a hit: accepted every other cycle.
      mark();
      @(posedge clk); #1;
      req = 1'b1; addr = 32'h40;
      idle(4);
      req = 1'b0;
      idle(2);
      check("b2b_acks", ack_cnt - ab, 2);
      check("b2b_inst", ack_inst, 32'hC0DE_0040);
      check("b2b_nreq", memlog.size() - lb, 0);

      // Conflict on index 4: 0x440 evicts 0x040, which then misses again.
      mark();
      do_req(32'h440);
      wait_ready(60, "conf_ready");
      idle(2);
      check("conf_nreq", memlog.size() - lb, 4);
      check("conf_first", memlog[lb], 32'h440);
      check("conf_last", memlog[lb+3], 32'h44C);
      check("conf_inst", ack_inst, 32'hC0DE_0440);
      mark();
      do_req(32'h040);
      wait_ready(60, "evict_ready");
      idle(2);
      check("evict_nreq", memlog.size() - lb, 4);
      check("evict_first", memlog[lb], 32'h40);
      check("evict_inst", ack_inst, 32'hC0DE_0040);

      // mem_busy held for 5 cycles in FILL_REQ.
      mark();
      mem_busy = 1'b1;
      do_req(32'h1238);
      repeat (5) @(negedge clk);
      check("busy_no_req", memlog.size() - lb, 0);
      check("busy_mem_req", {31'h0, mem_req}, 32'h0);
      @(posedge clk); #1;
      mem_busy = 1'b0;
      wait_ready(60, "busy_ready");
      idle(2);
      check("busy_nreq", memlog.size() - lb, 4);
      check("busy_first", memlog[lb], 32'h1230);
      check("busy_third", memlog[lb+2], 32'h1238);
      check("busy_acks", ack_cnt - ab, 1);
      check("busy_inst", ack_inst, 32'hC0DE_1238);

      // Reset after the second returned word abandons the fill.
      mark();
      do_req(32'h2008);
      for (int n = 0; n < 40 && (vcyc.size() - vb) < 2; n++) @(negedge clk);
      check("mid_v2", vcyc.size() - vb, 2);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_ready",    {31'h0, ready},   32'h1);
      check("mid_ack",      {31'h0, ack},     32'h0);
      check("mid_inst",     inst,             32'h0);
      check("mid_mem_req",  {31'h0, mem_req}, 32'h0);
      check("mid_mem_addr", mem_addr,         32'h0);
      idle(2);
      rst_n = 1'b1;
      ab = ack_cnt;
      lb = memlog.size();
      @(posedge clk); #1;
      stray_valid = 1'b1;
      @(posedge clk); #1;
      stray_valid = 1'b0;
      idle(2);
      check("stray_acks", ack_cnt - ab, 0);
      check("stray_nreq", memlog.size() - lb, 0);
      check("stray_ready", {31'h0, ready}, 32'h1);
      mark();
      do_req(32'h2008);
      wait_ready(60, "refill_ready");
      idle(2);
      check("refill_nreq", memlog.size() - lb, 4);
      check("refill_first", memlog[lb], 32'h2000);
      check("refill_last", memlog[lb+3], 32'h200C);
      check("refill_acks", ack_cnt - ab, 1);
      check("refill_inst", ack_inst, 32'hC0DE_2008);

      // A req pulsed during a fill is dropped.
      mark();
      do_req(32'h3000);
      idle(3);
      check("drop_busy", {31'h0, ready}, 32'h0);
      req = 1'b1; addr = 32'h44;
      idle(1);
      req = 1'b0;
      wait_ready(60, "drop_ready");
      idle(2);
      check("drop_acks", ack_cnt - ab, 1);
      check("drop_inst", ack_inst, 32'hC0DE_3000);
      check("drop_nreq", memlog.size() - lb, 4);

      // Requested word is the last word: ack and ready coincide.
      mark();
      do_req(32'h400C);
      wait_ready(60, "last_ready");
      idle(2);
      check("last_inst", ack_inst, 32'hC0DE_400C);
      check("last_ack_eq_ready", ack_cyc, ready_cyc);
      check("last_ready_lat", ready_cyc, vcyc[vb+3] + 1);

      check("inst_zero_without_ack", bad_inst, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
Parametrised direct-mapped instruction cache between fetch stage and instruction memory (wb_simulator-style port). Replaces the fixed 16-entry, single-origin cache with LINES x WORDS_PER_LINE storage, per-line tags, and single-port sequential line fill. It forwards the requested word early during a fill, and exposes a ready signal so fetch knows when a new request is accepted.

Parameters:
LINES, 16, number of cache lines; power of two, >=2
WORDS_PER_LINE, 4, 32-bit words per line; power of two, >=2
ADDR_W, 32, byte-address width
Derived, not overridable: WB=log2(WORDS_PER_LINE), IB=log2(LINES), TB=ADDR_W-IB-WB-2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  fetch request pulse; sampled only when ready=1
addr  in  ADDR_W  byte address of instruction; bits[1:0] ignored
ready  out  1  cache idle, can accept req
inst  out  32  instruction data; valid when ack=1, else 0
ack  out  1  one-cycle pulse per accepted req
mem_req  out  1  one-cycle read request pulse to memory
mem_addr  out  ADDR_W  word-aligned fill address; held from mem_req until mem_valid
mem_rdata  in  32  memory read data
mem_valid  in  1  read data valid pulse
mem_busy  in  1  memory cannot accept mem_req

Behaviour:
- Address split: offset=addr[1:0], word=addr[WB+1:2], index=addr[IB+WB+1:WB+2], tag=addr[ADDR_W-1:IB+WB+2].
- Storage per line: valid bit, TB-bit tag, WORDS_PER_LINE x 32 data. Line valid is set only after its last word is written.
- Reset (async, rst_n=0): all valid bits=0; state=IDLE; ready=1, ack=0, inst=0, mem_req=0, mem_addr=0; word counter=0. Reset mid-fill abandons the fill. A mem_valid arriving after reset release while in IDLE is ignored.
- States: IDLE, HIT_RESP, FILL_REQ, FILL_WAIT.
- IDLE: ready=1. On req, register tag, index, and word.
  - Hit (valid[index] && tag match): go to HIT_RESP.
  - Miss: clear valid[index], set fill counter=0, go to FILL_REQ.
- HIT_RESP: ack=1, inst=data[index][word], ready=0. Next state IDLE. Hit latency is req -> ack in 1 cycle; back-to-back hits are accepted every 2 cycles.
- FILL_REQ: ready=0. If mem_busy=1, wait with mem_req=0. Else mem_req=1 and mem_addr={tag,index,cnt,2'b00}; go to FILL_WAIT.
- FILL_WAIT: mem_addr held. On mem_valid, write mem_rdata into data[index][cnt].
  - If cnt==requested word: ack=1 and inst=mem_rdata in the cycle after mem_valid (registered, exactly one ack per request).
  - If cnt==WORDS_PER_LINE-1: set valid[index], store tag, go to IDLE. Else cnt+1, go to FILL_REQ.
- Fill order is always word 0 upward; no critical-word-first.
- ready stays 0 for the whole fill, even after the early ack. A req while ready=0 is dropped, with no ack and no state change; fetch must re-issue it.
- When the requested word is the last word, the ack cycle coincides with the return to IDLE; ready=1 in that same cycle.
- mem_valid outside FILL_WAIT is ignored.
- Counter width is WB bits; it never wraps within a fill.

Optional Feature:
ICACHE_PERF_EN: adds outputs hit_cnt[31:0] and miss_cnt[31:0]. They increment on an accepted req that hits or misses respectively, saturate at 32'hFFFFFFFF, and reset to 0. Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Cold miss (defaults): req addr=0x0000_0048 after reset -> mem_req for 0x40,0x44,0x48,0x4C in order; ack with inst=mem[0x48] one cycle after 3rd mem_valid; ready returns 1 after 4th mem_valid.
- Hit after fill: req 0x44 -> ack next cycle, inst=mem[0x44], no mem_req.
- Conflict eviction: fill 0x040, then req 0x440 (same index 4, tag differs) -> miss with full refill. A following req 0x040 misses again.
- mem_busy stall: hold mem_busy=1 for 5 cycles in FILL_REQ -> mem_req stays 0, then issues once with the correct mem_addr; data is correct.
- Reset mid-fill: drop rst_n after 2nd mem_valid -> outputs 0 immediately. Re-request the same addr -> misses and refills all 4 words.
- Dropped request: pulse req during a fill -> no extra ack, no extra mem_req. With ICACHE_PERF_EN, after scenarios 1-2: hit_cnt=1, miss_cnt=1.
